// File: rtl/spi_slave_rx_if.sv
// SPI slave pins plus the RX/TX byte streams of spi_slave_rx.
// slave: DUT side; master: SPI master / byte producer-consumer side.
interface spi_slave_rx_if;
  logic       spi_clk_i;
  logic       spi_mosi_i;
  logic       spi_cs_i;
  logic       spi_miso_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       busy_o;
  logic       rx_overrun_o;
  logic       tx_underrun_o;

  modport slave (
    input  spi_clk_i, spi_mosi_i, spi_cs_i,
    input  rx_ready_i, tx_data_i, tx_valid_i,
    output spi_miso_o, rx_data_o, rx_valid_o,
    output tx_ready_o, busy_o,
    output rx_overrun_o, tx_underrun_o
  );

  modport master (
    output spi_clk_i, spi_mosi_i, spi_cs_i,
    output rx_ready_i, tx_data_i, tx_valid_i,
    input  spi_miso_o, rx_data_o, rx_valid_o,
    input  tx_ready_o, busy_o,
    input  rx_overrun_o, tx_underrun_o
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-3 slave, oversampled by sys_clk: RX byte stream out, TX byte in.
// Ports: sys_clk, sys_rst_n (async low), bus (spi_slave_rx_if.slave).
// Option: SPI_SLAVE_RX_LOOPBACK_EN echoes last RX byte instead of IDLE_FILL.
module spi_slave_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  spi_slave_rx_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;

  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_d, rise_q, fall_q, mosi_q;
  logic [2:0] bit_cnt;
  logic [6:0] rx_acc;
  logic [7:0] rx_data, tx_hold, tx_shift;
  logic       rx_valid, tx_full;
  logic       overrun, underrun;
  logic       active, rise, fall, done;
  logic       consume, load, clr_flags;
  logic [7:0] rx_byte, fill;
  logic       fill_flag;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // Edge pulses are registered once more so MOSI and the
  // pulse stay aligned and RX latency is SYNC_STAGES+1.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_sync <= '1;
      mosi_sync <= '1;
      cs_sync   <= '1;
      sclk_d    <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      mosi_q    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_i};
      sclk_d    <= sclk_s;
      rise_q    <= sclk_s & ~sclk_d;
      fall_q    <= ~sclk_s & sclk_d;
      mosi_q    <= mosi_s;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    active    = 1'b0;
    unique case (state_q)
      IDLE:   if (!cs_s) state_d = ACTIVE;
      ACTIVE: begin
        active = 1'b1;
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rise      = active & rise_q;
    fall      = active & fall_q;
    done      = rise && (bit_cnt == 3'd7);
    load      = fall && (bit_cnt == 3'd0);
    rx_byte   = {rx_acc, mosi_q};
    consume   = rx_valid & bus.rx_ready_i;
    clr_flags = ~active & bus.rx_ready_i;
  end

`ifdef SPI_SLAVE_RX_LOOPBACK_EN
  assign fill      = rx_data;
  assign fill_flag = 1'b0;
`else
  assign fill      = IDLE_FILL;
  assign fill_flag = 1'b1;
`endif

  // Counter wraps 7->0 on the byte's last sample.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  bit_cnt <= 3'd0;
    else if (!active) bit_cnt <= 3'd0;
    else if (rise)    bit_cnt <= bit_cnt + 3'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_acc   <= 7'd0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (rise) rx_acc <= {rx_acc[5:0], mosi_q};
      // A same-cycle consume frees the slot for the new byte.
      if (done && (!rx_valid || bus.rx_ready_i)) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (consume) begin
        rx_valid <= 1'b0;
      end
      if (clr_flags)
        overrun <= 1'b0;
      else if (done && rx_valid && !bus.rx_ready_i)
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_hold  <= 8'h00;
      tx_full  <= 1'b0;
      tx_shift <= 8'hFF;
      underrun <= 1'b0;
    end else begin
      if (load)      tx_shift <= tx_full ? tx_hold : fill;
      else if (fall) tx_shift <= {tx_shift[6:0], 1'b1};
      if (bus.tx_valid_i && !tx_full) begin
        tx_hold <= bus.tx_data_i;
        tx_full <= 1'b1;
      end else if (load) begin
        tx_full <= 1'b0;
      end
      if (clr_flags)
        underrun <= 1'b0;
      else if (load && !tx_full && fill_flag)
        underrun <= 1'b1;
    end
  end

  assign bus.spi_miso_o    = active ? tx_shift[7] : 1'b1;
  assign bus.rx_data_o     = rx_data;
  assign bus.rx_valid_o    = rx_valid;
  assign bus.tx_ready_o    = ~tx_full;
  assign bus.busy_o        = active;
  assign bus.rx_overrun_o  = overrun;
  assign bus.tx_underrun_o = underrun;

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, legal 2..3: synchronizer depth on spi_clk_i, spi_mosi_i and spi_cs_i.
REQ-002 SHALL provide parameter IDLE_FILL, default 8'hFF: byte shifted out when no TX byte is held.
REQ-003 sys_clk  input  1  system clock; all logic on its rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 spi_clk_i  input  1  SPI clock from the master; mode 3, idles high.
REQ-006 spi_mosi_i  input  1  serial data from the master, MSB first.
REQ-007 spi_cs_i  input  1  chip select, active low.
REQ-008 spi_miso_o  output  1  serial data to the master, MSB first.
REQ-009 rx_data_o  output  8  received byte.
REQ-010 rx_valid_o  output  1  rx_data_o holds an unconsumed byte.
REQ-011 rx_ready_i  input  1  consumer accepts rx_data_o.
REQ-012 tx_data_i  input  8  byte to send.
REQ-013 tx_valid_i  input  1  tx_data_i is valid.
REQ-014 tx_ready_o  output  1  TX holding register is empty.
REQ-015 busy_o  output  1  synchronized chip select is active.
REQ-016 rx_overrun_o  output  1  sticky flag: a received byte was dropped.
REQ-017 tx_underrun_o  output  1  sticky flag: IDLE_FILL was sent.

Function
REQ-018 SHALL synchronize all SPI inputs through SYNC_STAGES flops and detect sclk rising and falling edges on the synchronized copy with one extra flop.
- SPI half-period SHALL be at least 2 sys_clk cycles; behaviour below that is undefined.
REQ-019 SHALL implement the FSM IDLE -> ACTIVE -> IDLE:
- IDLE -> ACTIVE on synchronized CS low.
- ACTIVE -> IDLE on synchronized CS high.
- bit counter 0..7 cleared on entering ACTIVE.
REQ-020 SHALL sample MOSI on each sclk rising edge in ACTIVE, MSB first.
- on the 8th sample: rx_data_o is written, rx_valid_o is set, and the bit counter wraps to 0.
REQ-021 rx_valid_o SHALL rise exactly SYNC_STAGES+1 sys_clk cycles after the sys_clk edge that first registers the 8th raw sclk rising edge.
REQ-022 rx_valid_o SHALL stay high until the cycle with rx_ready_i=1, then clear.
REQ-023 If a byte completes while rx_valid_o=1 and rx_ready_i=0:
- the new byte is dropped;
- rx_data_o is unchanged;
- rx_overrun_o is set.
REQ-024 If a byte completes in the same cycle as rx_ready_i=1 with rx_valid_o=1, the new byte SHALL load, rx_valid_o stays 1, and no overrun is flagged.
REQ-025 tx_ready_o SHALL be 1 while the holding register is empty.
- a byte is captured when tx_valid_i=1 and tx_ready_o=1.
- tx_ready_o drops on the next cycle.
REQ-026 On each sclk falling edge with bit counter 0:
- the shift register loads the held byte and tx_ready_o returns to 1;
- if no byte is held, it loads IDLE_FILL and tx_underrun_o is set.
REQ-027 spi_miso_o SHALL present the shift-register MSB, advancing one bit per sclk falling edge; it is driven 1 while in IDLE.
REQ-028 CS deasserted mid-byte:
- the partial RX byte is discarded with no rx_valid_o;
- the bit counter clears;
- a held TX byte not yet loaded is retained.
REQ-029 Flags rx_overrun_o and tx_underrun_o SHALL clear only on reset, or on a cycle with busy_o=0 and rx_ready_i=1.

Reset
REQ-030 Asserting sys_rst_n low SHALL immediately force:
- FSM to IDLE; bit counter to 0;
- spi_miso_o=1, rx_data_o=8'h00, rx_valid_o=0, tx_ready_o=1, busy_o=0;
- both flags to 0; synchronizers to CS=1 and SCLK=1.
REQ-031 Reset asserted mid-byte SHALL discard all RX and TX state; the first byte after release begins only after a fresh CS falling edge.

Configuration
REQ-032 Macro SPI_SLAVE_RX_LOOPBACK_EN:
- when defined, a byte boundary with no held TX byte SHALL send the last received byte instead of IDLE_FILL, and SHALL NOT set tx_underrun_o;
- when undefined, REQ-026 applies unchanged.

Verification
REQ-033 Scenario: CS low, master sends 8'hA5, rx_ready_i=1 -> rx_valid_o high one cycle with rx_data_o=8'hA5 at the REQ-021 latency.
REQ-034 Scenario: tx_data_i=8'h3C loaded before CS low, master clocks one byte -> MISO bits 0,0,1,1,1,1,0,0 sampled on rising edges; tx_ready_o returns to 1.
REQ-035 Scenario: two bytes 8'h11, 8'h22 with rx_ready_i=0 -> rx_data_o=8'h11, rx_overrun_o=1.
REQ-036 Scenario: no TX byte held, one byte clocked -> MISO reads 8'hFF, tx_underrun_o=1; with LOOPBACK_EN, MISO echoes the prior RX byte and the flag stays 0.
REQ-037 Scenario: CS raised after 5 bits -> no rx_valid_o; a following full byte 8'h5A is received correctly.
REQ-038 Scenario: sys_rst_n pulsed low mid-byte -> all outputs at REQ-030 values on the same cycle; the next full byte 8'hC3 is received correctly.
